// File: rtl/normalizer16bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : normalizer16bit_seq
// Purpose  : Sequential 16-bit left normalizer. Finds the left-shift
//            magnitude that moves the most significant set bit of A to
//            bit 15 and returns that magnitude with the normalized value.
//            A binary search over shift sizes 8/4/2/1 takes one cycle each.
// Ports    : clk    - rising-edge clock
//            reset  - synchronous, active-high reset
//            start  - request, sampled only when not busy
//            A      - operand, captured on the accepted start cycle
//            busy   - high during the four search cycles
//            done   - one-cycle pulse when Q/mag/zero are updated
//            Q      - normalized result (A << mag)
//            mag    - leading-zero count of A (0 for A == 0)
//            zero   - high when the captured A was 0x0000
// Revision : 1.0 - initial release
// ============================================================================
module normalizer16bit_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] A,
   output logic        busy,
   output logic        done,
   output logic [15:0] Q,
   output logic [3:0]  mag,
   output logic        zero
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S3   = 3'd1,
      S2   = 3'd2,
      S1   = 3'd3,
      S0   = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t      state_q;
   logic [15:0] w_q;        // work register being shifted
   logic [3:0]  m_q;        // magnitude bits accumulated so far
   logic        a_zero_q;   // captured operand was zero
   logic        busy_q;
   logic        done_q;
   logic [15:0] q_q;
   logic [3:0]  mag_q;
   logic        zero_q;

   logic [15:0] w_d;
   logic [3:0]  m_d;

   // One search step: if the top 2^k bits are all zero, shift them out and
   // record bit k of the magnitude.
   always_comb begin
      w_d = w_q;
      m_d = m_q;
      case (state_q)
         S3: if (w_q[15:8] == 8'h00) begin
            w_d    = {w_q[7:0], 8'h00};
            m_d[3] = 1'b1;
         end
         S2: if (w_q[15:12] == 4'h0) begin
            w_d    = {w_q[11:0], 4'h0};
            m_d[2] = 1'b1;
         end
         S1: if (w_q[15:14] == 2'b00) begin
            w_d    = {w_q[13:0], 2'b00};
            m_d[1] = 1'b1;
         end
         S0: if (w_q[15] == 1'b0) begin
            w_d    = {w_q[14:0], 1'b0};
            m_d[0] = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         w_q      <= 16'h0000;
         m_q      <= 4'h0;
         a_zero_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         q_q      <= 16'h0000;
         mag_q    <= 4'h0;
         zero_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  w_q      <= A;
                  m_q      <= 4'h0;
                  a_zero_q <= (A == 16'h0000);
                  busy_q   <= 1'b1;
                  state_q  <= S3;
               end else begin
                  state_q  <= IDLE;
               end
            end
            S3: begin
               w_q     <= w_d;
               m_q     <= m_d;
               state_q <= S2;
            end
            S2: begin
               w_q     <= w_d;
               m_q     <= m_d;
               state_q <= S1;
            end
            S1: begin
               w_q     <= w_d;
               m_q     <= m_d;
               state_q <= S0;
            end
            S0: begin
               w_q     <= w_d;
               m_q     <= m_d;
               // A zero operand runs through all steps setting every M bit;
               // the reported magnitude is forced to 0 in that case.
               q_q     <= a_zero_q ? 16'h0000 : w_d;
               mag_q   <= a_zero_q ? 4'h0 : m_d;
               zero_q  <= a_zero_q;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Q    = q_q;
   assign mag  = mag_q;
   assign zero = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_normalizer16bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_normalizer16bit_seq
// Purpose  : Self-checking bench for normalizer16bit_seq against a
//            leading-zero-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_normalizer16bit_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] A;
   logic        busy;
   logic        done;
   logic [15:0] Q;
   logic [3:0]  mag;
   logic        zero;

   int n_cmp;
   int n_err;

   normalizer16bit_seq dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .A     (A),
      .busy  (busy),
      .done  (done),
      .Q     (Q),
      .mag   (mag),
      .zero  (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: count leading zeros by scanning from the top bit.
   task automatic ref_norm(input logic [15:0] a, output logic [15:0] q,
                           output logic [3:0] m, output logic z);
      int lz;
      lz = 0;
      if (a == 16'h0000) begin
         q = 16'h0000; m = 4'h0; z = 1'b1;
      end else begin
         while (a[15 - lz] == 1'b0) lz++;
         m = lz[3:0];
         q = a << lz;
         z = 1'b0;
      end
   endtask

   // Launch one operation and wait (bounded) for done. lat = number of
   // negedges after the accepting edge until done is seen (-1 on timeout).
   task automatic do_op(input logic [15:0] a, output int lat, output int bcnt);
      @(negedge clk);
      A = a; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      A = 16'($urandom);
      lat = -1; bcnt = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (done) begin lat = i; break; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; A = 16'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
      n_cmp++; if (Q !== 16'h0000) begin n_err++; $display("FAIL reset_Q got=%h exp=0000", Q); end
      n_cmp++; if (mag !== 4'h0) begin n_err++; $display("FAIL reset_mag got=%0d exp=0", mag); end
      n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero got=%b exp=0", zero); end
   endtask

   task automatic test_single();
      int lat, bcnt;
      do_op(16'h0001, lat, bcnt);
      n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL single_latency got=%0d exp=5", lat); end
      n_cmp++; if (bcnt !== 4) begin n_err++; $display("FAIL single_busy_cycles got=%0d exp=4", bcnt); end
      n_cmp++; if (Q !== 16'h8000) begin n_err++; $display("FAIL single_Q got=%h exp=8000", Q); end
      n_cmp++; if (mag !== 4'd15) begin n_err++; $display("FAIL single_mag got=%0d exp=15", mag); end
      n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL single_zero got=%b exp=0", zero); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_pulse got=%b exp=0", done); end
   endtask

   task automatic test_directed();
      logic [15:0] vec [4];
      logic [15:0] eq; logic [3:0] em; logic ez;
      int lat, bcnt;
      vec[0] = 16'h0123; vec[1] = 16'h00F0; vec[2] = 16'h8000; vec[3] = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         ref_norm(vec[i], eq, em, ez);
         do_op(vec[i], lat, bcnt);
         n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL dir_latency A=%h got=%0d exp=5", vec[i], lat); end
         n_cmp++; if (Q !== eq) begin n_err++; $display("FAIL dir_Q A=%h got=%h exp=%h", vec[i], Q, eq); end
         n_cmp++; if (mag !== em) begin n_err++; $display("FAIL dir_mag A=%h got=%0d exp=%0d", vec[i], mag, em); end
         n_cmp++; if (zero !== ez) begin n_err++; $display("FAIL dir_zero A=%h got=%b exp=%b", vec[i], zero, ez); end
      end
   endtask

   task automatic test_ignore_busy();
      int pulses;
      logic [15:0] q1; logic [3:0] m1;
      q1 = 16'hxxxx; m1 = 4'hx; pulses = 0;
      @(negedge clk);
      A = 16'h0001; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);                 // S3
      @(negedge clk);                 // S2: second request
      A = 16'h4000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; A = 16'hFFFF;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (done) begin
            if (pulses == 0) begin q1 = Q; m1 = mag; end
            pulses++;
         end
      end
      n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL busy_ignore_pulses got=%0d exp=1", pulses); end
      n_cmp++; if (q1 !== 16'h8000) begin n_err++; $display("FAIL busy_ignore_Q got=%h exp=8000", q1); end
      n_cmp++; if (m1 !== 4'd15) begin n_err++; $display("FAIL busy_ignore_mag got=%0d exp=15", m1); end
   endtask

   task automatic test_back_to_back();
      int lat, bcnt;
      do_op(16'h0123, lat, bcnt);
      n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL b2b_first_latency got=%0d exp=5", lat); end
      // Currently in the DONE cycle: issue the next request.
      A = 16'h0010; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; A = 16'h0000;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i < 5) begin
            n_cmp++;
            if (done !== 1'b0 || Q !== 16'h9180 || mag !== 4'd7) begin
               n_err++;
               $display("FAIL b2b_hold cyc=%0d got done=%b Q=%h mag=%0d exp done=0 Q=9180 mag=7", i, done, Q, mag);
            end
         end else begin
            n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done got=%b exp=1", done); end
            n_cmp++; if (Q !== 16'h8000) begin n_err++; $display("FAIL b2b_Q got=%h exp=8000", Q); end
            n_cmp++; if (mag !== 4'd11) begin n_err++; $display("FAIL b2b_mag got=%0d exp=11", mag); end
         end
      end
   endtask

   task automatic test_reset_midop();
      int pulses, lat, bcnt;
      pulses = 0;
      @(negedge clk);
      A = 16'h00F0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);                 // S3
      @(negedge clk);                 // S2
      @(negedge clk);                 // S1
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      n_cmp++; if (Q !== 16'h0000) begin n_err++; $display("FAIL midrst_Q got=%h exp=0000", Q); end
      n_cmp++; if (mag !== 4'h0) begin n_err++; $display("FAIL midrst_mag got=%0d exp=0", mag); end
      n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL midrst_zero got=%b exp=0", zero); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL midrst_no_done got=%0d exp=0", pulses); end
      do_op(16'h0300, lat, bcnt);
      n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL midrst_fresh_latency got=%0d exp=5", lat); end
      n_cmp++; if (Q !== 16'hC000 || mag !== 4'd6 || zero !== 1'b0) begin
         n_err++; $display("FAIL midrst_fresh got Q=%h mag=%0d zero=%b exp Q=c000 mag=6 zero=0", Q, mag, zero);
      end
   endtask

   task automatic test_random();
      logic [15:0] a, eq; logic [3:0] em; logic ez;
      int lat, bcnt;
      for (int n = 0; n < 1000; n++) begin
         a = 16'($urandom) >> $urandom_range(0, 16);
         ref_norm(a, eq, em, ez);
         do_op(a, lat, bcnt);
         n_cmp++;
         if (lat !== 5 || Q !== eq || mag !== em || zero !== ez) begin
            n_err++;
            $display("FAIL rand A=%h got lat=%0d Q=%h mag=%0d zero=%b exp lat=5 Q=%h mag=%0d zero=%b",
                     a, lat, Q, mag, zero, eq, em, ez);
         end
         if (a != 16'h0000) begin
            n_cmp++;
            if (Q[15] !== 1'b1 || (Q >> mag) !== a) begin
               n_err++;
               $display("FAIL rand_invariant A=%h got Q=%h mag=%0d exp Q[15]=1 and Q>>mag=A", a, Q, mag);
            end
         end
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      reset = 1'b1; start = 1'b0; A = 16'h0;
      test_reset();
      test_single();
      test_directed();
      test_ignore_busy();
      test_back_to_back();
      test_reset_midop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
